// File: rtl/mem_lsu_if.sv
// Data-bus interface between the MEM-stage load/store unit and memory.
// req is held with stable we/addr/wdata/be until gnt; load data returns later with rvalid.
interface mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: bus request sequencing, lane steering, load extension,
// pipeline hold while an access is in flight, and a request/wait timeout.
module mem_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic        rd_wen_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_data_i,
  input  logic        mem_we_i,
  input  logic        mem_re_i,
  mem_lsu_if.master   bus,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_wen_o,
  output logic        hold_flag_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [4:0]       rd_addr_q, rd_addr_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             load_ok_q, load_ok_d;

  logic [2:0]  funct3_in;
  logic        req_in;
  logic        legal_in;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_be;
  logic [31:0] rdata_shift;
  logic [31:0] rdata_fmt;
  logic        timeout;

  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;

  logic        unused_inst;
  assign unused_inst = ^{inst_i[31:15], inst_i[11:0]};

  assign funct3_in = inst_i[14:12];
  assign req_in    = mem_we_i | mem_re_i;
  assign timeout   = (cnt_q == CNT_LAST);

  // A request with both enables high is a store, so load-only widths are illegal then.
  always_comb begin
    legal_in = 1'b0;
    case (funct3_in)
      3'b000:  legal_in = 1'b1;
      3'b001:  legal_in = ~mem_addr_i[0];
      3'b010:  legal_in = (mem_addr_i[1:0] == 2'b00);
      3'b100:  legal_in = ~mem_we_i;
      3'b101:  legal_in = ~mem_we_i & ~mem_addr_i[0];
      default: legal_in = 1'b0;
    endcase
  end

  always_comb begin
    lane_wdata = data_q;
    lane_be    = 4'b1111;
    case (funct3_q[1:0])
      2'b00: begin
        lane_wdata = {4{data_q[7:0]}};
        lane_be    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        lane_wdata = {2{data_q[15:0]}};
        lane_be    = 4'b0011 << addr_q[1:0];
      end
      default: begin
        lane_wdata = data_q;
        lane_be    = 4'b1111;
      end
    endcase
  end

  assign rdata_shift = bus.rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    rdata_fmt = bus.rdata;
    case (funct3_q)
      3'b000:  rdata_fmt = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  rdata_fmt = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  rdata_fmt = {24'd0, rdata_shift[7:0]};
      3'b101:  rdata_fmt = {16'd0, rdata_shift[15:0]};
      default: rdata_fmt = bus.rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    funct3_d    = funct3_q;
    rd_addr_d   = rd_addr_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    load_ok_d   = load_ok_q;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = 32'd0;
    bus_wdata   = 32'd0;
    bus_be      = 4'd0;
    rd_addr_o   = 5'd0;
    rd_data_o   = 32'd0;
    rd_wen_o    = 1'b0;
    hold_flag_o = 1'b0;
    misalign_o  = 1'b0;
    bus_err_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!req_in) begin
          rd_addr_o = rd_addr_i;
          rd_data_o = rd_data_i;
          rd_wen_o  = rd_wen_i;
        end else if (!legal_in) begin
          misalign_o = 1'b1;
        end else begin
          addr_d      = mem_addr_i;
          data_d      = mem_data_i;
          funct3_d    = funct3_in;
          rd_addr_d   = rd_addr_i;
          we_d        = mem_we_i;
          cnt_d       = '0;
          load_ok_d   = 1'b0;
          hold_flag_o = 1'b1;
          state_d     = S_REQ;
        end
      end

      S_REQ: begin
        hold_flag_o = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = S_DONE;
        end else begin
          bus_req   = 1'b1;
          bus_we    = we_q;
          bus_addr  = {addr_q[31:2], 2'b00};
          bus_wdata = lane_wdata;
          bus_be    = lane_be;
          if (bus.gnt) begin
            state_d = we_q ? S_DONE : S_WAIT;
          end
        end
      end

      S_WAIT: begin
        hold_flag_o = 1'b1;
        cnt_d       = cnt_q + CNT_W'(1);
        if (timeout) begin
          bus_err_o = 1'b1;
          state_d   = S_DONE;
        end else if (bus.rvalid) begin
          rdata_d   = rdata_fmt;
          load_ok_d = 1'b1;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        // load_ok_q is only set by a captured load, so stores and timeouts never write back.
        rd_addr_o = rd_addr_q;
        rd_data_o = load_ok_q ? rdata_q : 32'd0;
        rd_wen_o  = load_ok_q;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      funct3_q  <= 3'd0;
      rd_addr_q <= 5'd0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= 32'd0;
      load_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      funct3_q  <= funct3_d;
      rd_addr_q <= rd_addr_d;
      we_q      <= we_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      load_ok_q <= load_ok_d;
    end
  end

  assign bus.req     = bus_req;
  assign bus.we      = bus_we;
  assign bus.addr    = bus_addr;
  assign bus.wdata   = bus_wdata;
  assign bus.be      = bus_be;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: bus transfers, write-backs and error pulses are
// queued as expected when issued and checked by a separate monitor.
module tb_mem_lsu;
  localparam int TO = 64;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] EVT_MIS = 2'd1;
  localparam logic [1:0] EVT_ERR = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic        rd_wen_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic        mem_we_i;
  logic        mem_re_i;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        rd_wen_o;
  logic        hold_flag_o;
  logic        misalign_o;
  logic        bus_err_o;
  logic [1:0]  dbg_state_o;

  mem_lsu_if bus_if();

  mem_lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst_i      (inst_i),
    .rd_addr_i   (rd_addr_i),
    .rd_data_i   (rd_data_i),
    .rd_wen_i    (rd_wen_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_we_i    (mem_we_i),
    .mem_re_i    (mem_re_i),
    .bus         (bus_if),
    .rd_addr_o   (rd_addr_o),
    .rd_data_o   (rd_data_o),
    .rd_wen_o    (rd_wen_o),
    .hold_flag_o (hold_flag_o),
    .misalign_o  (misalign_o),
    .bus_err_o   (bus_err_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [68:0] exp_bus_q[$];  // {we, addr, wdata, be}
  logic [36:0] exp_wb_q[$];   // {rd_addr, rd_data}
  logic [1:0]  exp_evt_q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got unexpected output event expected none (t=%0t)", name, $time);
  endtask

  function automatic logic [110:0] all_outs();
    return {bus_if.req, bus_if.we, bus_if.addr, bus_if.wdata, bus_if.be,
            rd_addr_o, rd_data_o, rd_wen_o, hold_flag_o, misalign_o, bus_err_o};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.req && bus_if.gnt) begin
        if (exp_bus_q.size() == 0) unexpected("bus_txn");
        else check("bus_txn", {bus_if.we, bus_if.addr, bus_if.wdata, bus_if.be}, exp_bus_q.pop_front());
      end
      if (rd_wen_o) begin
        if (exp_wb_q.size() == 0) unexpected("writeback");
        else check("writeback", {rd_addr_o, rd_data_o}, exp_wb_q.pop_front());
      end
      if (misalign_o) begin
        if (exp_evt_q.size() == 0) unexpected("misalign");
        else check("misalign_evt", EVT_MIS, exp_evt_q.pop_front());
      end
      if (bus_err_o) begin
        if (exp_evt_q.size() == 0) unexpected("bus_err");
        else check("bus_err_evt", EVT_ERR, exp_evt_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic clear_inputs();
    inst_i = 32'd0; rd_addr_i = 5'd0; rd_data_i = 32'd0; rd_wen_i = 1'b0;
    mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_we_i = 1'b0; mem_re_i = 1'b0;
    bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pass(input logic [4:0] rd, input logic [31:0] data, input logic wen);
    inst_i = 32'h0000_0033; rd_addr_i = rd; rd_data_i = data; rd_wen_i = wen;
    if (wen) exp_wb_q.push_back({rd, data});
    @(negedge clk);
    check("pass_hold", hold_flag_o, 1'b0);
    check("pass_data", rd_data_o, data);
    next_cycle();
    clear_inputs();
  endtask

  // Bus slave behaviour: gnt on the gnt_dly-th request cycle, rvalid on the rv_dly-th wait cycle.
  task automatic do_access(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data,
                           input logic we, input logic re_too, input logic [4:0] rd,
                           input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                           output int holds, output int reqs);
    int req_cyc;
    int wait_cyc;
    bit done;
    holds = 0; reqs = 0; req_cyc = 0; wait_cyc = 0; done = 1'b0;
    inst_i     = {17'd0, f3, 5'd0, we ? 7'h23 : 7'h03};
    mem_addr_i = addr;
    mem_data_i = data;
    mem_we_i   = we;
    mem_re_i   = ~we | re_too;
    rd_addr_i  = rd;
    rd_wen_i   = ~we;
    rd_data_i  = 32'd0;
    for (int n = 0; n < 200 && !done; n++) begin
      bus_if.gnt = 1'b0; bus_if.rvalid = 1'b0; bus_if.rdata = rdata;
      #1;
      if (bus_if.req) begin
        if (req_cyc == gnt_dly) bus_if.gnt = 1'b1;
        req_cyc++;
      end
      if (dbg_state_o == ST_WAIT) begin
        if (wait_cyc == rv_dly) bus_if.rvalid = 1'b1;
        wait_cyc++;
      end
      @(negedge clk);
      if (hold_flag_o) holds++;
      if (bus_if.req) reqs++;
      done = !hold_flag_o;
      next_cycle();
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL access_budget: got hold still high expected release within 200 cycles");
    end
    clear_inputs();
  endtask

  int holds, reqs;

  initial begin
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    @(negedge clk);
    check("reset_outs", all_outs(), 111'd0);
    check("reset_state", dbg_state_o, ST_IDLE);
    next_cycle();
    rst = 1'b0;

    pass(5'd5, 32'h1234_5678, 1'b1);
    pass(5'd6, 32'hAAAA_0001, 1'b0);

    // LW 0x100, gnt on second request cycle, rvalid on first wait cycle
    exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b1111});
    exp_wb_q.push_back({5'd3, 32'hDEAD_BEEF});
    do_access(3'b010, 32'h100, 32'h0, 1'b0, 1'b0, 5'd3, 1, 0, 32'hDEAD_BEEF, holds, reqs);
    check("lw_hold_cycles", holds, 4);

    exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b1000});
    exp_wb_q.push_back({5'd4, 32'hFFFF_FF80});
    do_access(3'b000, 32'h103, 32'h0, 1'b0, 1'b0, 5'd4, 0, 0, 32'h8012_3456, holds, reqs);
    check("lb_hold_cycles", holds, 3);

    exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b1000});
    exp_wb_q.push_back({5'd5, 32'h0000_0080});
    do_access(3'b100, 32'h103, 32'h0, 1'b0, 1'b0, 5'd5, 0, 0, 32'h8012_3456, holds, reqs);

    exp_bus_q.push_back({1'b0, 32'h100, 32'h0, 4'b1100});
    exp_wb_q.push_back({5'd6, 32'hFFFF_8012});
    do_access(3'b001, 32'h102, 32'h0, 1'b0, 1'b0, 5'd6, 0, 2, 32'h8012_3456, holds, reqs);
    check("lh_hold_cycles", holds, 5);

    exp_bus_q.push_back({1'b0, 32'h200, 32'h0, 4'b0011});
    exp_wb_q.push_back({5'd7, 32'h0000_F00D});
    do_access(3'b101, 32'h200, 32'h0, 1'b0, 1'b0, 5'd7, 0, 0, 32'h1234_F00D, holds, reqs);

    exp_bus_q.push_back({1'b1, 32'h100, 32'hABCD_ABCD, 4'b1100});
    do_access(3'b001, 32'h102, 32'h1234_ABCD, 1'b1, 1'b0, 5'd0, 0, 0, 32'h0, holds, reqs);
    check("sh_hold_cycles", holds, 2);

    exp_bus_q.push_back({1'b1, 32'h200, 32'hA5A5_A5A5, 4'b0010});
    do_access(3'b000, 32'h201, 32'h0000_00A5, 1'b1, 1'b0, 5'd0, 3, 0, 32'h0, holds, reqs);
    check("sb_hold_cycles", holds, 5);

    exp_bus_q.push_back({1'b1, 32'h300, 32'hCAFE_F00D, 4'b1111});
    do_access(3'b010, 32'h300, 32'hCAFE_F00D, 1'b1, 1'b1, 5'd9, 0, 0, 32'h0, holds, reqs);
    check("sw_both_hold", holds, 2);

    // misaligned / illegal accesses never reach the bus
    exp_evt_q.push_back(EVT_MIS);
    do_access(3'b001, 32'h101, 32'h0, 1'b0, 1'b0, 5'd2, 0, 0, 32'h0, holds, reqs);
    check("lh_mis_hold", holds, 0);
    check("lh_mis_reqs", reqs, 0);
    exp_evt_q.push_back(EVT_MIS);
    do_access(3'b010, 32'h102, 32'h0, 1'b0, 1'b0, 5'd2, 0, 0, 32'h0, holds, reqs);
    check("lw_mis_reqs", reqs, 0);
    exp_evt_q.push_back(EVT_MIS);
    do_access(3'b100, 32'h0, 32'h0, 1'b1, 1'b0, 5'd0, 0, 0, 32'h0, holds, reqs);
    check("sbu_illegal_hold", holds, 0);
    exp_evt_q.push_back(EVT_MIS);
    do_access(3'b011, 32'h0, 32'h0, 1'b0, 1'b0, 5'd1, 0, 0, 32'h0, holds, reqs);
    check("f3_011_illegal_reqs", reqs, 0);

    // timeout: gnt never comes
    exp_evt_q.push_back(EVT_ERR);
    do_access(3'b010, 32'h500, 32'h0, 1'b0, 1'b0, 5'd10, 1000, 0, 32'h0, holds, reqs);
    check("timeout_hold", holds, TO + 1);
    check("timeout_reqs", reqs, TO - 1);
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'h7777_7777;
    pass(5'd11, 32'h0000_0042, 1'b1);

    // reset while waiting for read data
    inst_i = {17'd0, 3'b010, 5'd0, 7'h03};
    mem_addr_i = 32'h400; mem_re_i = 1'b1; rd_addr_i = 5'd8; rd_wen_i = 1'b1;
    next_cycle();
    bus_if.gnt = 1'b1;
    exp_bus_q.push_back({1'b0, 32'h400, 32'h0, 4'b1111});
    next_cycle();
    bus_if.gnt = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    bus_if.rvalid = 1'b1; bus_if.rdata = 32'h1111_1111;
    @(negedge clk);
    check("rst_mid_outs", all_outs(), 111'd0);
    check("rst_mid_state", dbg_state_o, ST_IDLE);
    next_cycle();
    bus_if.rvalid = 1'b0;
    pass(5'd9, 32'h0000_0055, 1'b1);

    repeat (3) next_cycle();
    check("bus_q_drained", exp_bus_q.size(), 0);
    check("wb_q_drained", exp_wb_q.size(), 0);
    check("evt_q_drained", exp_evt_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: got run still active expected finish by 200000");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
